// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, synchronous I-memory request issue, and a
// 2-entry {instr, pc} queue presented to decode over valid/ready.
`default_nettype none

module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] infl_pc_q, infl_pc_d;
  logic            infl_q, infl_d;
  logic [1:0]      count_q, count_d;
  logic [31:0]     instr_q [2];
  logic [31:0]     instr_d [2];
  logic [XLEN-1:0] epc_q [2];
  logic [XLEN-1:0] epc_d [2];

  logic pop, push, issue, wr_idx;

  assign pop   = out_valid & out_ready;
  assign push  = infl_q & ~redirect_valid;
  // Gated by rst_n so no request is seen while reset is held.
  assign issue = rst_n & ~redirect_valid
               & (((count_q + {1'b0, infl_q}) < 2'd2) | pop);
  // Slot for the incoming entry after any same-cycle pop (count_q - pop).
  assign wr_idx = count_q[0] ^ pop;

  assign imem_req     = issue;
  assign imem_addr    = pc_q;
  assign out_valid    = (count_q != 2'd0);
  assign out_instr    = instr_q[0];
  assign out_pc       = epc_q[0];
  assign out_pc_plus4 = epc_q[0] + XLEN'(4);

  always_comb begin
    pc_d      = pc_q;
    infl_pc_d = infl_pc_q;
    infl_d    = issue;
    instr_d   = instr_q;
    epc_d     = epc_q;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};

    if (issue) begin
      pc_d      = pc_q + XLEN'(4);
      infl_pc_d = pc_q;
    end
    if (pop) begin
      instr_d[0] = instr_q[1];
      epc_d[0]   = epc_q[1];
    end
    if (push) begin
      instr_d[wr_idx] = imem_rdata;
      epc_d[wr_idx]   = infl_pc_q;
    end
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = redirect_pc & ~XLEN'(3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      infl_pc_q  <= '0;
      infl_q     <= 1'b0;
      count_q    <= 2'd0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      epc_q[0]   <= '0;
      epc_q[1]   <= '0;
    end else begin
      assert (count_q != 2'd3);
      pc_q      <= pc_d;
      infl_pc_q <= infl_pc_d;
      infl_q    <= infl_d;
      count_q   <= count_d;
      instr_q   <= instr_d;
      epc_q     <= epc_d;
    end
  end

endmodule

`default_nettype wire
